// File: rtl/simple_bus_arbiter_if.sv
// simple_bus_arbiter_if: requester-side and memory-side signals of the shared simple_bus.
interface simple_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        m_req, m_start, m_gnt, m_rdy;
  logic [2*NUM_REQ-1:0]      m_mode;
  logic [ADDR_W*NUM_REQ-1:0] m_addr;
  logic [DATA_W*NUM_REQ-1:0] m_wdata;
  logic [DATA_W-1:0]         m_rdata, s_wdata, s_rdata;
  logic [ADDR_W-1:0]         s_addr;
  logic [1:0]                s_mode;
  logic                      s_req, s_gnt, s_start, s_rdy, err;
  modport master (
    input  m_req, m_start, m_mode, m_addr, m_wdata, s_gnt, s_rdata, s_rdy,
    output m_gnt, m_rdy, m_rdata, s_req, s_start, s_mode, s_addr, s_wdata, err
  );
  modport slave (
    output m_req, m_start, m_mode, m_addr, m_wdata, s_gnt, s_rdata, s_rdy,
    input  m_gnt, m_rdy, m_rdata, s_req, s_start, s_mode, s_addr, s_wdata, err
  );
endinterface

// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin sharing of one simple_bus memory among NUM_REQ requesters.
// Define SIMPLE_BUS_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles without s_rdy (pulses err).
module simple_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input logic clk,
  input logic rst_n,
  simple_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, REQ, OWN, BUSY} state_t;
  state_t state, state_nx;
  logic [IW-1:0] owner, owner_nx, last, last_nx;
  logic [CW-1:0] burst_cnt, burst_nx;
  logic s_req_nx, gnt_nx, start_nx, rdy_nx, rel;
  logic [1:0] mode_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx, rdata_nx;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_nx;
  logic err_nx;
`endif

  // first requester after lst in circular order; lst itself has lowest priority
  function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] lst);
    int j;
    pick = lst;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(lst) + i) % NUM_REQ;
      if (req[j]) pick = IW'(j);
    end
  endfunction

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    burst_nx = burst_cnt;
    s_req_nx = bus.s_req;
    gnt_nx   = |bus.m_gnt;
    start_nx = 1'b0;
    rdy_nx   = 1'b0;
    rel      = 1'b0;
    rdata_nx = bus.m_rdata;
    addr_nx  = bus.s_addr;
    mode_nx  = bus.s_mode;
    wdata_nx = bus.s_wdata;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    tcnt_nx  = '0;
    err_nx   = 1'b0;
`endif
    case (state)
      IDLE: if (|bus.m_req) begin
        state_nx = REQ;
        owner_nx = pick(bus.m_req, last);
        s_req_nx = 1'b1;
      end
      REQ: if (!bus.m_req[owner]) begin
        state_nx = IDLE;
        s_req_nx = 1'b0;
      end else if (bus.s_gnt) begin
        state_nx = OWN;
        gnt_nx   = 1'b1;
      end
      OWN: if (!bus.m_req[owner]) rel = 1'b1;
      else if (!bus.s_gnt) begin
        state_nx = REQ;
        gnt_nx   = 1'b0;
      end else if (bus.m_start[owner]) begin
        state_nx = BUSY;
        start_nx = 1'b1;
        addr_nx  = bus.m_addr[owner*ADDR_W +: ADDR_W];
        mode_nx  = bus.m_mode[owner*2 +: 2];
        wdata_nx = bus.m_wdata[owner*DATA_W +: DATA_W];
      end
      BUSY: begin
        if (bus.s_rdy) begin
          rdy_nx   = 1'b1;
          rdata_nx = bus.s_rdata;
          burst_nx = burst_cnt + 1'b1;
          state_nx = OWN;
          rel      = (burst_cnt == CW'(MAX_BURST - 1)) || !bus.m_req[owner];
        end
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_nx = 1'b1;
          rel    = 1'b1;
        end else tcnt_nx = tcnt + 1'b1;
`endif
      end
      default: state_nx = IDLE;
    endcase
    if (rel) begin
      state_nx = IDLE;
      s_req_nx = 1'b0;
      gnt_nx   = 1'b0;
      last_nx  = owner;
      burst_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      last        <= IW'(NUM_REQ - 1);
      burst_cnt   <= '0;
      bus.s_req   <= 1'b0;
      bus.m_gnt   <= '0;
      bus.s_start <= 1'b0;
      bus.m_rdy   <= '0;
      bus.m_rdata <= '0;
      bus.s_addr  <= '0;
      bus.s_mode  <= '0;
      bus.s_wdata <= '0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      last        <= last_nx;
      burst_cnt   <= burst_nx;
      bus.s_req   <= s_req_nx;
      bus.m_gnt   <= {{(NUM_REQ-1){1'b0}}, gnt_nx} << owner_nx;
      bus.s_start <= start_nx;
      bus.m_rdy   <= {{(NUM_REQ-1){1'b0}}, rdy_nx} << owner;
      bus.m_rdata <= rdata_nx;
      bus.s_addr  <= addr_nx;
      bus.s_mode  <= mode_nx;
      bus.s_wdata <= wdata_nx;
    end
  end

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt    <= '0;
      bus.err <= 1'b0;
    end else begin
      tcnt    <= tcnt_nx;
      bus.err <= err_nx;
    end
  end
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: directed and random stimulus checked against a transaction-level model.
module tb_simple_bus_arbiter;
  localparam int N = 4, AW = 8, DW = 8, MB = 4, TO = 15;
  localparam int OW = 1 + N + 1 + AW + 2 + DW + N + DW + 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  simple_bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  simple_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int vectors = 0, miscompares = 0;
  // model: who is asking/holding/transferring, plus round-robin memory
  bit asking, held, xfer;
  int own, last, beats, tmo;
  logic [N-1:0] one = 1, e_gnt, e_rdy;
  logic e_sreq, e_start, e_err;
  logic [1:0] e_mode;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_rdata, e_wdata;

  function automatic logic [OW-1:0] outs();
    return {bus.s_req, bus.m_gnt, bus.s_start, bus.s_addr, bus.s_mode, bus.s_wdata, bus.m_rdy, bus.m_rdata, bus.err};
  endfunction

  function automatic int rr(input logic [N-1:0] req, input int from);
    for (int k = 1; k <= N; k++) if (req[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  task automatic release_bus();
    asking = 0; held = 0; xfer = 0; last = own; beats = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      asking = 0; held = 0; xfer = 0; own = 0; last = N - 1; beats = 0; tmo = 0;
      e_start = 0; e_rdy = '0; e_err = 0; e_rdata = '0; e_addr = '0; e_mode = '0; e_wdata = '0;
    end else begin
      e_start = 0; e_rdy = '0; e_err = 0;
      if (!asking) begin
        if (bus.m_req != 0) begin own = rr(bus.m_req, last); asking = 1; end
      end else if (!xfer && !bus.m_req[own]) begin
        if (held) release_bus(); else asking = 0;
      end else if (!held) begin
        held = bus.s_gnt;
      end else if (!xfer) begin
        if (!bus.s_gnt) held = 0;
        else if (bus.m_start[own]) begin
          xfer = 1; tmo = 0; e_start = 1;
          e_addr = bus.m_addr[own*AW +: AW];
          e_mode = bus.m_mode[own*2 +: 2];
          e_wdata = bus.m_wdata[own*DW +: DW];
        end
      end else if (bus.s_rdy) begin
        e_rdy = one << own; e_rdata = bus.s_rdata; xfer = 0; beats++;
        if (beats == MB || !bus.m_req[own]) release_bus();
      end else begin
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
        tmo++;
        if (tmo == TO) begin e_err = 1; release_bus(); end
`endif
      end
    end
    e_sreq = asking;
    e_gnt = held ? one << own : '0;
    #1;
    vectors++;
    if (outs() !== {e_sreq, e_gnt, e_start, e_addr, e_mode, e_wdata, e_rdy, e_rdata, e_err}) begin
      miscompares++;
      $display("FAIL cycle_compare t=%0t: got %h expected %h", $time, outs(),
               {e_sreq, e_gnt, e_start, e_addr, e_mode, e_wdata, e_rdy, e_rdata, e_err});
    end
  end

  task automatic do_reset();
    rst_n = 0; bus.m_req = '0; bus.m_start = '0; bus.s_gnt = 0; bus.s_rdy = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(outs()), 0);
    rst_n = 1;
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int c = 0; c < 30 && idx < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus.m_gnt[i]) idx = i;
    end
    if (idx < 0) begin
      vectors++; miscompares++;
      $display("FAIL grant_wait: got no m_gnt within 30 cycles, required one");
    end
  endtask

  task automatic txn(input int idx, input bit drop);
    logic [DW-1:0] rd;
    if (idx < 0) return;
    bus.m_start[idx] = 1;
    bus.m_addr[idx*AW +: AW] = AW'($urandom);
    bus.m_mode[idx*2 +: 2] = 2'($urandom);
    bus.m_wdata[idx*DW +: DW] = DW'($urandom);
    @(negedge clk);
    bus.m_start = '0;
    if (drop) bus.m_req[idx] = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rd = DW'($urandom); bus.s_rdata = rd; bus.s_rdy = 1;
    @(negedge clk);
    bus.s_rdy = 0;
    chk("txn_m_rdy", 64'(bus.m_rdy), 64'(one << idx));
    chk("txn_m_rdata", 64'(bus.m_rdata), 64'(rd));
  endtask

  initial begin
    int idx, n;
    bus.m_req = '0; bus.m_start = '0; bus.m_mode = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_gnt = 0; bus.s_rdy = 0; bus.s_rdata = '0;
    // single requester, exact latencies
    do_reset();
    bus.m_req = 4'b0001;
    @(negedge clk); chk("s_req_latency", 64'(bus.s_req), 1);
    bus.s_gnt = 1;
    @(negedge clk); chk("m_gnt_single", 64'(bus.m_gnt), 4'b0001);
    bus.m_start = 4'b0001; bus.m_addr[7:0] = 8'h5A; bus.m_mode[1:0] = 2'd2; bus.m_wdata[7:0] = 8'h11;
    @(negedge clk);
    chk("s_start_on", 64'(bus.s_start), 1);
    chk("s_addr", 64'(bus.s_addr), 8'h5A);
    chk("s_mode", 64'(bus.s_mode), 2);
    bus.m_start = '0;
    @(negedge clk); chk("s_start_pulse", 64'(bus.s_start), 0);
    @(negedge clk); bus.s_rdy = 1; bus.s_rdata = 8'hC3;
    @(negedge clk); bus.s_rdy = 0;
    chk("m_rdy_single", 64'(bus.m_rdy), 4'b0001);
    chk("m_rdata_single", 64'(bus.m_rdata), 8'hC3);
    @(negedge clk);
    chk("m_rdy_pulse", 64'(bus.m_rdy), 0);
    chk("s_addr_held", 64'(bus.s_addr), 8'h5A);
    // round-robin order
    do_reset();
    bus.s_gnt = 1; bus.m_req = '1;
    for (int k = 0; k < N; k++) begin wait_gnt(idx); chk("rr_order", 64'(idx), 64'(k)); txn(idx, 1); end
    bus.m_req = '1;
    for (int k = 0; k < 2; k++) begin wait_gnt(idx); chk("rr_resume", 64'(idx), 64'(k)); txn(idx, 1); end
    // burst cap
    do_reset();
    bus.s_gnt = 1; bus.m_req = 4'b0101;
    wait_gnt(idx); chk("burst_first", 64'(idx), 0);
    for (int k = 1; k <= 4; k++) begin
      txn(0, 0);
      chk("burst_gnt", 64'(bus.m_gnt), k < 4 ? 64'd1 : 64'd0);
    end
    wait_gnt(idx); chk("burst_next", 64'(idx), 2); txn(idx, 1);
    wait_gnt(idx); chk("burst_resume", 64'(idx), 0); txn(idx, 0); txn(idx, 0);
    // stray inputs
    do_reset();
    bus.s_gnt = 1; bus.m_req = 4'b0011;
    wait_gnt(idx); chk("stray_owner", 64'(idx), 0);
    bus.m_start = 4'b0010;
    @(negedge clk); bus.m_start = '0;
    chk("stray_start", 64'(bus.s_start), 0);
    chk("stray_gnt", 64'(bus.m_gnt), 4'b0001);
    bus.s_rdy = 1;
    @(negedge clk); bus.s_rdy = 0;
    chk("stray_rdy", 64'(bus.m_rdy), 0);
    chk("stray_gnt2", 64'(bus.m_gnt), 4'b0001);
    // reset mid-BUSY
    bus.m_start = 4'b0001;
    @(negedge clk); bus.m_start = '0;
    chk("busy_start", 64'(bus.s_start), 1);
    rst_n = 0; bus.m_req = '0;
    @(negedge clk); chk("mid_reset_outputs", 64'(outs()), 0);
    rst_n = 1; bus.m_req = 4'b0100;
    wait_gnt(idx); chk("post_reset_gnt", 64'(idx), 2);
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    bus.m_start = 4'b0100;
    @(negedge clk); bus.m_start = '0;
    chk("tmo_start", 64'(bus.s_start), 1);
    n = 0;
    while (!bus.err && n < 40) begin @(negedge clk); n++; end
    chk("tmo_cycles", 64'(n), TO);
    chk("tmo_s_req", 64'(bus.s_req), 0);
    chk("tmo_m_rdy", 64'(bus.m_rdy), 0);
`endif
    // random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 7) == 0) bus.m_req = N'($urandom);
      bus.m_start = N'($urandom) & N'($urandom) & N'($urandom);
      bus.m_addr = (AW*N)'($urandom);
      bus.m_mode = (2*N)'($urandom);
      bus.m_wdata = (DW*N)'($urandom);
      bus.s_gnt = $urandom_range(0, 9) != 0;
      bus.s_rdy = $urandom_range(0, 3) == 0;
      bus.s_rdata = DW'($urandom);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/simple_bus_arbiter.md
Name: simple_bus_arbiter

Overview:
- Shares one simple_bus memory target between NUM_REQ CPU-side requesters.
- Arbitrates round-robin, then owns the bus handshake toward the memory: req/gnt, start pulse, wait for rdy.
- Forwards the owner's addr, mode and write data; returns read data and rdy to the owner only.
- Sits between the cpu instances and the memory instance in top. Replaces the direct cpu-to-mem hookup.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- MAX_BURST, 4: transactions one owner may complete per tenure before re-arbitration.
- TIMEOUT, 15: BUSY-state cycles allowed before abort (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- m_req  in  NUM_REQ  per-requester bus request (level).
- m_start  in  NUM_REQ  per-requester transaction start (1-cycle pulse).
- m_mode  in  2*NUM_REQ  packed per-requester mode.
- m_addr  in  ADDR_W*NUM_REQ  packed per-requester address.
- m_wdata  in  DATA_W*NUM_REQ  packed per-requester write data.
- m_gnt  out  NUM_REQ  one-hot grant.
- m_rdy  out  NUM_REQ  one-hot completion pulse.
- m_rdata  out  DATA_W  read data, valid with m_rdy.
- s_req  out  1  request to memory.
- s_gnt  in  1  grant from memory.
- s_start  out  1  start pulse to memory.
- s_mode  out  2  mode to memory.
- s_addr  out  ADDR_W  address to memory.
- s_wdata  out  DATA_W  write data to memory.
- s_rdata  in  DATA_W  read data from memory.
- s_rdy  in  1  completion from memory.
- err  out  1  timeout abort pulse.

Behaviour:
- Reset and outputs:
  - One clock, clk.
  - Reset is synchronous, active-low (rst_n sampled at posedge clk).
  - Reset forces state to IDLE and all outputs to 0.
  - Reset clears burst_cnt and the timeout counter.
  - Reset sets the round-robin pointer last to NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts immediately. No m_rdy is issued.
  - All outputs are registered.
- States:
  - IDLE: if m_req != 0, owner := first set bit searching last+1, last+2, ... (mod NUM_REQ). Go to REQ and set s_req=1.
  - REQ: s_req=1. When s_gnt=1, go to OWN and set m_gnt[owner]=1. If m_req[owner] drops first, go to IDLE and clear s_req.
  - OWN:
    - When m_start[owner]=1, go to BUSY.
    - On entry to BUSY: s_start=1 for exactly one cycle.
    - On entry to BUSY: register s_addr/s_mode/s_wdata from owner's slice; they are held until the next start.
    - If m_req[owner]=0, go to IDLE: clear s_req and m_gnt, and set last := owner.
    - If s_gnt=0, go to REQ and clear m_gnt.
  - BUSY:
    - When s_rdy=1: m_rdata := s_rdata, m_rdy[owner]=1 for one cycle, burst_cnt++.
    - After completion, go to IDLE (release, last := owner) if burst_cnt+1 == MAX_BURST or m_req[owner]=0. Otherwise go to OWN.
- Latency: m_req seen to s_req takes 1 cycle. s_gnt to m_gnt takes 1 cycle. m_start to s_start takes 1 cycle. s_rdy to m_rdy takes 1 cycle.
- burst_cnt clears on every release.
- Ignored inputs and events:
  - m_start from non-owners, and m_start outside OWN.
  - s_rdy outside BUSY.
  - s_gnt deassertion during BUSY; the transaction completes.
  - m_req drop during BUSY; the transaction completes, then the bus is released.
- Simultaneous release and new request: the IDLE arbitration in the next cycle uses the updated last, so a released owner never wins over another pending requester.
- A single lone requester may re-win after the one-cycle IDLE gap.
- Requests change only in IDLE. A new m_req during another's tenure waits.

Optional Feature:
- Macro: SIMPLE_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments every cycle in BUSY.
  - If it reaches TIMEOUT with s_rdy still 0: err=1 for one cycle, no m_rdy, go to IDLE with release and last := owner, counter cleared.
  - If s_rdy arrives in the same cycle the counter reaches TIMEOUT, s_rdy wins and err stays 0.
- Undefined: BUSY waits indefinitely, err is tied 0, no counter logic.

Test Plan:
- Single requester:
  - Stimulus: reset, m_req=0001, s_gnt returns 1 cycle after s_req, m_start[0] pulse with addr 0x5A, mode 2; s_rdy 3 cycles later with s_rdata 0xC3.
  - Required: s_start is one cycle with s_addr=0x5A, s_mode=2; m_rdy=0001 one cycle with m_rdata=0xC3.
- Round-robin:
  - Stimulus: m_req=1111 held, each owner does one transaction then drops req.
  - Required: grant order 0,1,2,3. With req restored, order continues 0,1,...
- Burst cap:
  - Stimulus: MAX_BURST=4, requesters 0 and 2 held high, requester 0 issues 6 starts.
  - Required: 4 m_rdy pulses to 0, release, grant to 2 before 0 resumes.
- Non-owner and stray inputs:
  - Stimulus: m_start[1] while 0 owns; s_rdy pulse in OWN.
  - Required: no s_start, no m_rdy, state unchanged.
- Reset mid-BUSY:
  - Stimulus: rst_n=0 for one cycle during BUSY.
  - Required: next cycle all outputs 0, state IDLE. A following m_req=0100 is granted to requester 2.
- Timeout (SIMPLE_BUS_ARB_TIMEOUT_EN, TIMEOUT=15):
  - Stimulus: s_rdy never asserted.
  - Required: err pulses exactly 15 cycles after s_start, s_req drops, no m_rdy.
